srpt_header_arbiter: RTL and testbench

- Merges up to NUM_SRC header sources into the single header_in FIFO read interface of the SRPT grant queue (srpt_grant_pkts).
- Each source is a first-word-fall-through FIFO read port.
- Weighted round-robin, with up to BURST consecutive headers per source, sequences which source's header enters the grant queue next.
- A one-entry holding register decouples the source side from the grant queue side, so a full-rate stream never stalls.

---
 rtl/srpt_header_arbiter.sv | 134 +++++++++++++
 tb/tb_srpt_header_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/srpt_header_arbiter.sv
// Weighted round-robin merge of NUM_SRC FWFT header FIFOs into one holding register that feeds the SRPT grant queue.
// Define SRPT_HEADER_ARB_STATS_EN to add per-source pop counters readable through stat_sel_i/stat_count_o.
module srpt_header_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 125,
    parameter int BURST   = 2,
    parameter int SRC_W   = 2
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NUM_SRC-1:0]        src_empty_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    output logic [NUM_SRC-1:0]        src_read_en_o,
    output logic                      header_in_empty_o,
    output logic [DATA_W-1:0]         header_in_data_o,
    output logic [SRC_W-1:0]          header_in_src_o,
    input  logic                      header_in_read_en_i
`ifdef SRPT_HEADER_ARB_STATS_EN
    ,
    input  logic [SRC_W-1:0]          stat_sel_i,
    output logic [31:0]               stat_count_o
`endif
);

    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0]   BURST_C = CNT_W'(BURST);
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [SRC_W-1:0]  hold_src_q, hold_src_d;
    logic [SRC_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  burst_q, burst_d;

    logic              slot_free;
    logic              any_src;
    logic              take_cur;
    logic              do_pop;
    logic              scan_found;
    logic [SRC_W-1:0]  scan_pick;
    logic [SRC_W-1:0]  cand;
    logic [SRC_W-1:0]  pick;
    logic [DATA_W-1:0] pick_data;

    // Rotating scan starts just after cur and visits cur itself last.
    always_comb begin
        scan_pick  = cur_q;
        scan_found = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(cur_q) + k) % NUM_SRC);
            if (!scan_found && !src_empty_i[cand]) begin
                scan_found = 1'b1;
                scan_pick  = cand;
            end
        end
    end

    // burst_q==0 only after reset, meaning no source owns a burst yet.
    assign take_cur  = (burst_q != '0) && (burst_q < BURST_C) && !src_empty_i[cur_q];
    assign pick      = take_cur ? cur_q : scan_pick;
    assign any_src   = ~&src_empty_i;
    assign slot_free = !hold_valid_q || header_in_read_en_i;
    assign do_pop    = slot_free && any_src && !ap_rst;
    assign pick_data = src_data_i[int'(pick)*DATA_W +: DATA_W];

    assign src_read_en_o     = do_pop ? (ONE_HOT0 << pick) : '0;
    assign header_in_empty_o = !hold_valid_q;
    assign header_in_data_o  = hold_data_q;
    assign header_in_src_o   = hold_src_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_src_d   = hold_src_q;
        cur_d        = cur_q;
        burst_d      = burst_q;
        if (do_pop) begin
            hold_valid_d = 1'b1;
            hold_data_d  = pick_data;
            hold_src_d   = pick;
            if (pick == cur_q) begin
                if (burst_q < BURST_C) begin
                    burst_d = burst_q + CNT_W'(1);
                end
            end else begin
                cur_d   = pick;
                burst_d = CNT_W'(1);
            end
        end else if (hold_valid_q && header_in_read_en_i) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_src_q   <= '0;
            cur_q        <= SRC_W'(NUM_SRC - 1);
            burst_q      <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_src_q   <= hold_src_d;
            cur_q        <= cur_d;
            burst_q      <= burst_d;
        end
    end

`ifdef SRPT_HEADER_ARB_STATS_EN
    logic [31:0] stat_cnt_q [NUM_SRC];
    logic [31:0] stat_count_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                stat_cnt_q[i] <= '0;
            end
            stat_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_read_en_o[i]) begin
                    stat_cnt_q[i] <= stat_cnt_q[i] + 32'd1;
                end
            end
            stat_count_q <= stat_cnt_q[stat_sel_i];
        end
    end

    assign stat_count_o = stat_count_q;
`endif

endmodule

// File: tb/tb_srpt_header_arbiter.sv
// Directed bench for srpt_header_arbiter: a vector table for arbitration order plus hand sequences
// for single header hold/release and reset in mid-operation.
module tb_srpt_header_arbiter;

    localparam int NS = 4;
    localparam int DW = 125;
    localparam int SW = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [NS-1:0]     src_empty;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_read_en;
    logic              hdr_empty;
    logic [DW-1:0]     hdr_data;
    logic [SW-1:0]     hdr_src;
    logic              hdr_rd;
    logic [DW-1:0]     word [NS];
`ifdef SRPT_HEADER_ARB_STATS_EN
    logic [SW-1:0]     stat_sel;
    logic [31:0]       stat_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        src_data = '0;
        for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = word[i];
    end

    srpt_header_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .BURST(2), .SRC_W(SW)) dut (
        .ap_clk              (ap_clk),
        .ap_rst              (ap_rst),
        .src_empty_i         (src_empty),
        .src_data_i          (src_data),
        .src_read_en_o       (src_read_en),
        .header_in_empty_o   (hdr_empty),
        .header_in_data_o    (hdr_data),
        .header_in_src_o     (hdr_src),
        .header_in_read_en_i (hdr_rd)
`ifdef SRPT_HEADER_ARB_STATS_EN
        ,
        .stat_sel_i          (stat_sel),
        .stat_count_o        (stat_count)
`endif
    );

    typedef struct {
        logic [3:0] empty;
        logic       rd;
        logic [3:0] ren;
        logic       hempty;
        logic [1:0] hsrc;
    } vec_t;

    vec_t tbl [27];

    function automatic logic [DW-1:0] pattern(input int i);
        return {15'(i + 1), 14'(i), 32'(i * 16), 32'hA5A5_0000 | 32'(i), 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input logic [3:0] e, input logic r);
        src_empty = e;
        hdr_rd    = r;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ren, input logic he,
                              input logic [1:0] hs, input logic [DW-1:0] hd);
        chk($sformatf("%s ren", tag), 128'(src_read_en), 128'(ren));
        chk($sformatf("%s hempty", tag), 128'(hdr_empty), 128'(he));
        if (!he) begin
            chk($sformatf("%s hsrc", tag), 128'(hdr_src), 128'(hs));
            chk($sformatf("%s hdata", tag), 128'(hdr_data), 128'(hd));
        end
    endtask

    initial begin
        logic [DW-1:0] hdr1;
        hdr1 = {15'h5, 14'h3333, 32'h10, 32'h4, 32'h0};

        // state before each row: cur/burst as left by the previous row (BURST=2)
        tbl[0]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[1]  = '{4'b1011, 1'b0, 4'b0100, 1'b1, 2'd0};
        tbl[2]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[6]  = '{4'b1100, 1'b1, 4'b0001, 1'b1, 2'd2};
        tbl[7]  = '{4'b1100, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[8]  = '{4'b1100, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[9]  = '{4'b1100, 1'b1, 4'b0010, 1'b0, 2'd1};
        tbl[10] = '{4'b1100, 1'b1, 4'b0001, 1'b0, 2'd1};
        tbl[11] = '{4'b1100, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[12] = '{4'b0111, 1'b1, 4'b1000, 1'b0, 2'd0};
        tbl[13] = '{4'b0111, 1'b1, 4'b1000, 1'b0, 2'd3};
        tbl[14] = '{4'b0111, 1'b1, 4'b1000, 1'b0, 2'd3};
        tbl[15] = '{4'b0111, 1'b1, 4'b1000, 1'b0, 2'd3};
        tbl[16] = '{4'b1010, 1'b1, 4'b0001, 1'b0, 2'd3};
        tbl[17] = '{4'b1011, 1'b1, 4'b0100, 1'b0, 2'd0};
        tbl[18] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2};
        tbl[19] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[20] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[22] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[23] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[24] = '{4'b0000, 1'b1, 4'b1000, 1'b0, 2'd2};
        tbl[25] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[26] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};

        for (int i = 0; i < NS; i++) word[i] = pattern(i);
        ap_rst    = 1'b1;
        src_empty = '1;
        hdr_rd    = 1'b0;
`ifdef SRPT_HEADER_ARB_STATS_EN
        stat_sel  = '0;
`endif
        @(negedge ap_clk);
        ap_rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            apply(4'b1111, 1'b0);
            check_outs($sformatf("idle%0d", c), 4'b0000, 1'b1, 2'd0, '0);
            @(negedge ap_clk);
        end

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i].empty, tbl[i].rd);
            check_outs($sformatf("vec%0d", i), tbl[i].ren, tbl[i].hempty, tbl[i].hsrc,
                       pattern(int'(tbl[i].hsrc)));
            @(negedge ap_clk);
        end

        // single header from source 2, held under no read, then released
        word[2] = hdr1;
        apply(4'b1011, 1'b0);
        check_outs("single pop", 4'b0100, 1'b1, 2'd0, '0);
        @(negedge ap_clk);
        for (int c = 0; c < 4; c++) begin
            apply(4'b1111, 1'b0);
            check_outs($sformatf("single hold%0d", c), 4'b0000, 1'b0, 2'd2, hdr1);
            @(negedge ap_clk);
        end
        apply(4'b1111, 1'b1);
        check_outs("single read", 4'b0000, 1'b0, 2'd2, hdr1);
        @(negedge ap_clk);
        apply(4'b1111, 1'b0);
        check_outs("single drained", 4'b0000, 1'b1, 2'd0, '0);
        @(negedge ap_clk);
        word[2] = pattern(2);

        // reset while a header is held and source 1 still has data
        apply(4'b1101, 1'b0);
        check_outs("rst prefill", 4'b0010, 1'b1, 2'd0, '0);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        apply(4'b1101, 1'b0);
        chk("rst cycle ren", 128'(src_read_en), 128'(4'b0000));
        chk("rst cycle held", 128'(hdr_empty), 128'(1'b0));
        @(negedge ap_clk);
        ap_rst = 1'b0;
        apply(4'b1111, 1'b0);
        check_outs("post rst", 4'b0000, 1'b1, 2'd0, '0);
        chk("post rst data", 128'(hdr_data), 128'(0));
        chk("post rst src", 128'(hdr_src), 128'(0));
`ifdef SRPT_HEADER_ARB_STATS_EN
        for (int s = 0; s < NS; s++) begin
            stat_sel = SW'(s);
            @(posedge ap_clk);
            #1;
            chk($sformatf("stat%0d after rst", s), 128'(stat_count), 128'(0));
        end
        @(negedge ap_clk);
`endif
        @(negedge ap_clk);
        apply(4'b1001, 1'b0);
        check_outs("first pop after rst", 4'b0010, 1'b1, 2'd0, '0);
        @(negedge ap_clk);
        apply(4'b1111, 1'b0);
        check_outs("first hold after rst", 4'b0000, 1'b0, 2'd1, pattern(1));
`ifdef SRPT_HEADER_ARB_STATS_EN
        stat_sel = 2'd1;
        @(posedge ap_clk);
        #1;
        chk("stat1 one pop", 128'(stat_count), 128'(1));
        stat_sel = 2'd2;
        @(posedge ap_clk);
        #1;
        chk("stat2 no pop", 128'(stat_count), 128'(0));
`endif
        @(negedge ap_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
